// File: rtl/multdiv_sched.sv
// Sequencer for the shared multiply/divide unit: latches a request, issues one start
// pulse, stalls the pipeline until ready or watchdog expiry, then strobes completion.
module multdiv_sched #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_mult,
   input  logic             req_div,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             md_ctrl_mult,
   output logic             md_ctrl_div,
   output logic [WIDTH-1:0] md_operand_a,
   output logic [WIDTH-1:0] md_operand_b,
   input  logic [WIDTH-1:0] md_result,
   input  logic             md_exception,
   input  logic             md_ready,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic [TAG_W-1:0] result_tag,
   output logic             timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_e;

   state_e             state_q, state_d;
   logic               op_mult_q, op_mult_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               to_q, to_d;
   logic [CNT_W-1:0]   busy_cnt;

   // Count as seen in the current BUSY cycle (1 in the first BUSY cycle).
   assign busy_cnt = cnt_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      op_mult_d    = op_mult_q;
      tag_d        = tag_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      exc_d        = exc_q;
      to_d         = to_q;
      md_ctrl_mult = 1'b0;
      md_ctrl_div  = 1'b0;
      stall        = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if ((req_mult | req_div) & ~flush) begin
               stall     = 1'b1;
               op_mult_d = req_mult;
               tag_d     = req_tag;
               opa_d     = operand_a;
               opb_d     = operand_b;
               state_d   = StLaunch;
            end
         end
         StLaunch: begin
            cnt_d = '0;
            if (flush) begin
               state_d = StIdle;
            end else begin
               stall        = 1'b1;
               md_ctrl_mult = op_mult_q;
               md_ctrl_div  = ~op_mult_q;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               stall = 1'b1;
               cnt_d = busy_cnt;
               if (md_ready) begin
                  result_d = md_result;
                  exc_d    = md_exception;
                  to_d     = 1'b0;
                  state_d  = StDone;
               end else if (busy_cnt == CNT_W'(TIMEOUT)) begin
                  result_d = '0;
                  exc_d    = 1'b1;
                  to_d     = 1'b1;
                  state_d  = StDone;
               end
            end
         end
         StDone: begin
            // Request is still present here; returning to IDLE lets the pipeline advance.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         op_mult_q <= 1'b0;
         tag_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_mult_q <= op_mult_d;
         tag_q     <= tag_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
         to_q      <= to_d;
      end
   end

   assign done         = (state_q == StDone);
   assign md_operand_a = opa_q;
   assign md_operand_b = opb_q;
   assign result       = result_q;
   assign exception    = exc_q;
   assign timeout      = to_q;
   assign result_tag   = tag_q;

endmodule

// File: tb/tb_multdiv_sched.sv
// Bench for multdiv_sched: directed test-plan steps followed by random operations,
// each checked against a cycle-timeline model of the request/launch/busy/done sequence.
module tb_multdiv_sched;

   localparam int TMO = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_mult, req_div, flush;
   logic [4:0]  req_tag;
   logic [31:0] operand_a, operand_b;
   logic        md_ctrl_mult, md_ctrl_div;
   logic [31:0] md_operand_a, md_operand_b;
   logic [31:0] md_result;
   logic        md_exception, md_ready;
   logic        stall, done, exception, timeout;
   logic [31:0] result;
   logic [4:0]  result_tag;

   int errors = 0;
   int checks = 0;

   multdiv_sched #(.WIDTH(32), .TAG_W(5), .TIMEOUT(TMO)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_mult     (req_mult),
      .req_div      (req_div),
      .req_tag      (req_tag),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .flush        (flush),
      .md_ctrl_mult (md_ctrl_mult),
      .md_ctrl_div  (md_ctrl_div),
      .md_operand_a (md_operand_a),
      .md_operand_b (md_operand_b),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_ready     (md_ready),
      .stall        (stall),
      .done         (done),
      .result       (result),
      .exception    (exception),
      .result_tag   (result_tag),
      .timeout      (timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         req_mult = 1'b0; req_div = 1'b0; flush = 1'b0; md_ready = 1'b0;
         @(negedge clock);
         chk("idle_stall", stall, 0);
         chk("idle_done", done, 0);
         chk("idle_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      end
   endtask

   // One request from acceptance cycle c=0. k: BUSY cycle in which the unit is ready
   // (0 = never). flush_c: cycle with flush=1 (-1 = none). stale: ready pulse during LAUNCH.
   task automatic run_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int k, input int flush_c,
                         input bit stale);
      logic [31:0] unit_res, exp_res;
      logic        unit_exc, exp_exc, exp_to;
      bit          timed, flushed;
      int          done_c, last;
      if (mult) begin
         unit_res = a * b;
         unit_exc = 1'b0;
      end else if (b == 0) begin
         unit_res = '1;
         unit_exc = 1'b1;
      end else begin
         unit_res = a / b;
         unit_exc = 1'b0;
      end
      timed   = (k == 0) || (k > TMO);
      done_c  = timed ? TMO + 2 : k + 2;
      exp_res = timed ? 32'd0 : unit_res;
      exp_exc = timed ? 1'b1 : unit_exc;
      exp_to  = timed;
      flushed = (flush_c >= 0) && (flush_c < done_c);
      last    = flushed ? flush_c + 2 : done_c;
      for (int c = 0; c <= last; c++) begin
         bit live, req;
         live = !flushed || (c <= flush_c);
         req  = live && (c <= done_c);
         @(posedge clock); #1;
         req_mult     = req && mult;
         req_div      = req && !mult;
         req_tag      = tag;
         operand_a    = a;
         operand_b    = b;
         flush        = (c == flush_c);
         md_ready     = (k > 0 && c == k + 1) || (stale && c == 1);
         md_result    = unit_res;
         md_exception = unit_exc;
         @(negedge clock);
         chk("stall", stall, live && (c < done_c) && (c != flush_c));
         chk("pulse_mult", md_ctrl_mult, live && mult && c == 1 && c != flush_c);
         chk("pulse_div", md_ctrl_div, live && !mult && c == 1 && c != flush_c);
         chk("done", done, !flushed && c == done_c);
         if (!flushed && c >= 1) begin
            chk("md_operand_a", md_operand_a, a);
            chk("md_operand_b", md_operand_b, b);
         end
         if (!flushed && c == done_c) begin
            chk("result", result, exp_res);
            chk("exception", exception, exp_exc);
            chk("timeout", timeout, exp_to);
            chk("result_tag", result_tag, tag);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req_mult = 1'b0; req_div = 1'b0; flush = 1'b0; req_tag = '0;
      operand_a = '0; operand_b = '0;
      md_result = '0; md_exception = 1'b0; md_ready = 1'b0;

      // Reset state, sampled between edges while reset is held
      #3;
      chk("rst_done", done, 0);
      chk("rst_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {exception, timeout}, 0);
      chk("rst_tag", result_tag, 0);
      chk("rst_operands", {md_operand_a, md_operand_b}, 0);
      chk("rst_stall", stall, 0);
      #5 reset = 1'b0;
      idle_cycles(2);

      // Test-plan directed steps
      run_op(1'b1, 32'd7, -32'sd3, 5'd9, 3, -1, 1'b0);
      run_op(1'b0, 32'd5, 32'd0, 5'd4, 1, -1, 1'b0);
      run_op(1'b1, 32'd12, 32'd11, 5'd1, 2, -1, 1'b0);
      run_op(1'b0, 32'd100, 32'd7, 5'd2, 2, -1, 1'b0);
      run_op(1'b1, 32'd3, 32'd3, 5'd17, 0, -1, 1'b0);
      run_op(1'b1, 32'd9, 32'd2, 5'd18, TMO, -1, 1'b1);
      run_op(1'b1, 32'd4, 32'd5, 5'd3, 3, 3, 1'b0);
      run_op(1'b0, 32'd8, 32'd2, 5'd6, 2, 1, 1'b0);
      run_op(1'b0, 32'd8, 32'd2, 5'd7, 2, 4, 1'b0);
      idle_cycles(1);

      // Asynchronous reset while BUSY
      @(posedge clock); #1;
      req_mult = 1'b1; operand_a = 32'hdead; operand_b = 32'hbeef; req_tag = 5'd21;
      @(posedge clock);
      @(posedge clock); #1;
      chk("busy_stall", stall, 1);
      #2 reset = 1'b1;
      #1;
      chk("rstbusy_done", done, 0);
      chk("rstbusy_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      chk("rstbusy_operand", md_operand_a, 0);
      chk("rstbusy_stall_req", stall, 1);
      req_mult = 1'b0;
      #1;
      chk("rstbusy_stall_idle", stall, 0);
      @(negedge clock) reset = 1'b0;
      idle_cycles(1);

      // Random operations
      for (int n = 0; n < 30; n++) begin
         bit          m;
         logic [31:0] ra, rb;
         int          rk, rf;
         m  = ($urandom_range(0, 1) == 1);
         ra = $urandom;
         rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         rk = $urandom_range(0, TMO + 2);
         rf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2) : -1;
         run_op(m, ra, rb, 5'($urandom), rk, rf, ($urandom_range(0, 1) == 1));
      end
      idle_cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/multdiv_sched.md
# multdiv_sched

Sequencer that owns the shared multiply/divide unit behind the execute stage. It accepts a mult/div request from the execute stage and latches the operands and destination tag. It issues exactly one start pulse to the unit, freezes the pipeline until the unit reports ready or a watchdog expires, and then returns the result with a one-cycle completion strobe. This replaces ad-hoc edge-detect triggering and stall logic in the processor top level.

## Interface
- WIDTH, 32, operand/result width
- TAG_W, 5, destination register tag width
- TIMEOUT, 40, max BUSY cycles to wait for unit ready (>=1)

- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  reset; asynchronous, active-high
- req_mult  in  1  execute stage holds a mult (level, held while stalled)
- req_div  in  1  execute stage holds a div (level)
- req_tag  in  TAG_W  destination register of the request
- operand_a, operand_b  in  WIDTH  bypassed execute operands
- flush  in  1  kill in-flight/pending operation
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses to the unit
- md_operand_a, md_operand_b  out  WIDTH  latched operands, stable from LAUNCH through DONE
- md_result  in  WIDTH  unit result
- md_exception  in  1  unit exception (e.g. divide by zero)
- md_ready  in  1  unit result valid
- stall  out  1  freeze PC and pipeline latches (combinational)
- done  out  1  one-cycle completion strobe
- result  out  WIDTH  registered result, valid while done=1
- exception  out  1  registered exception, valid while done=1
- result_tag  out  TAG_W  tag of completed op, valid while done=1
- timeout  out  1  high with done when the watchdog fired

## Operation
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE: if (req_mult|req_div) & ~flush, latch operands, tag, and op (mult wins if both are set), then go to LAUNCH. Otherwise stay.
- LAUNCH: drive md_ctrl_mult or md_ctrl_div = 1 for this cycle only. Clear the watchdog counter. Ignore md_ready (stale). Go to BUSY.
- BUSY: the counter increments each cycle and reads 1 in the first BUSY cycle.
  - md_ready=1: capture md_result and md_exception, set timeout=0, go to DONE.
  - Else if count==TIMEOUT: capture result=0, exception=1, timeout=1, go to DONE.
- DONE: done=1, stall=0. The pipeline advances on this edge. Go to IDLE unconditionally, so the still-present request is never relaunched.
- Flush in LAUNCH/BUSY: next state IDLE; start pulse suppressed in that cycle; no done; captured result discarded.
- Flush in DONE: ignored (completion stands).
- stall = IDLE: (req_mult|req_div)&~flush; LAUNCH/BUSY: ~flush; DONE: 0.
- md_ready outside BUSY has no effect.
- Counter width: clog2(TIMEOUT+1). It never wraps.

## Timing
- Reset (async): state IDLE, counter 0, latched operands/tag 0, result/exception/timeout/done 0. Both start pulses 0. stall reflects IDLE equation.
- Reset asserted mid-operation: IDLE immediately, no done, no pulse.
- Request seen in cycle R: stall=1 in R; LAUNCH (pulse) in R+1; BUSY from R+2.
- Ready in the k-th BUSY cycle (k>=1): DONE in cycle R+k+2; stall high R..R+k+1 (k+2 cycles).
- Watchdog: DONE at R+TIMEOUT+2.
- Back-to-back: a new request is accepted earliest in cycle R+k+3 (IDLE after DONE); zero dead cycles beyond that.
- Exactly one start pulse per accepted request; never two pulses without an intervening DONE or flush.

## Test plan
- Reset: assert reset mid-cycle, check all outputs 0 asynchronously. With no request, stall=0.
- Mult 7 x -3, tag 9, unit model ready on 3rd BUSY cycle:
  - md_ctrl_mult single pulse at R+1; stall high R..R+4.
  - done at R+5 with result=-21, tag=9, exception=0, timeout=0.
- Div 5/0, model returns exception on 1st BUSY cycle: md_ctrl_div pulse at R+1, done at R+3 with exception=1, timeout=0.
- Mult then div back-to-back, each ready on 2nd BUSY cycle:
  - Exactly one pulse each; second request accepted in the cycle after the first DONE.
  - Correct tags per done.
- TIMEOUT=8, ready never asserted: done at R+10 with result=0, exception=1, timeout=1; stall released at R+10.
- Flush and reset interactions:
  - Flush on 2nd BUSY cycle: no done; a stray md_ready 1 cycle later is ignored; stall=0 in the flush cycle.
  - Flush in LAUNCH: no pulse emitted.
  - Reset asserted on BUSY: state IDLE immediately.
